sha256_block_sequencer: RTL and testbench

Control and buffering stage directly upstream of the SHA-256 round core. It accepts one 512-bit message block as sixteen 32-bit words over a valid/ready stream and holds the chaining hash H0..H7. It drives the core's load/select/message/initial-hash inputs for 64 rounds, then adds the core's working variables into H0..H7. It presents the resulting 256-bit digest on a valid/ready output, supporting multi-block chaining.

---
 rtl/sha256_block_sequencer.sv | 142 ++++++++++++++
 tb/tb_sha256_block_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_sequencer.sv
// Buffers one 512-bit block, sequences the SHA-256 round core through 64 rounds and
// folds the working variables into the chaining hash, presenting it as a 256-bit digest.
module sha256_block_sequencer #(
  parameter int ROUND_CYCLES = 66
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_first,
  output logic         control,
  output logic [6:0]   select,
  output logic [31:0]  message_in,
  output logic [31:0]  h1,
  output logic [31:0]  h2,
  output logic [31:0]  h3,
  output logic [31:0]  h4,
  output logic [31:0]  h5,
  output logic [31:0]  h6,
  output logic [31:0]  h7,
  output logic [31:0]  h8,
  input  logic [31:0]  a,
  input  logic [31:0]  b,
  input  logic [31:0]  c,
  input  logic [31:0]  d,
  input  logic [31:0]  e,
  input  logic [31:0]  f,
  input  logic [31:0]  g,
  input  logic [31:0]  h,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest
);

  typedef enum logic [2:0] {S_FILL, S_LOAD, S_ROUND, S_FINAL, S_OUT} state_t;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [6:0]   RC_LAST = 7'(ROUND_CYCLES - 1);

  state_t       state_q, state_d;
  logic [3:0]   wcnt_q, wcnt_d;
  logic [6:0]   rcnt_q, rcnt_d;
  logic [31:0]  wbuf_q [16];
  logic [31:0]  wbuf_d [16];
  logic [255:0] hash_q, hash_d;
  logic         in_ready_q, in_ready_d;
  logic         control_q, control_d;
  logic [6:0]   select_q, select_d;
  logic [31:0]  message_in_q, message_in_d;
  logic         out_valid_q, out_valid_d;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    wbuf_d  = wbuf_q;
    hash_d  = hash_q;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          wbuf_d[wcnt_q] = in_data;
          wcnt_d         = wcnt_q + 4'd1;
          if (wcnt_q == 4'd0 && in_first) hash_d = IV;
          if (wcnt_q == 4'd15) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rcnt_d  = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        rcnt_d = rcnt_q + 7'd1;
        if (rcnt_q == RC_LAST) begin
          rcnt_d  = '0;
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        hash_d  = {hash_q[255:224] + a, hash_q[223:192] + b,
                   hash_q[191:160] + c, hash_q[159:128] + d,
                   hash_q[127:96]  + e, hash_q[95:64]   + f,
                   hash_q[63:32]   + g, hash_q[31:0]    + h};
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          wcnt_d  = '0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase

    // Core-facing outputs are computed from the next state so they are plain flops.
    in_ready_d   = (state_d == S_FILL);
    control_d    = (state_d == S_LOAD);
    out_valid_d  = (state_d == S_OUT);
    select_d     = '0;
    message_in_d = '0;
    if (state_d == S_ROUND) begin
      select_d = (rcnt_d > 7'd64) ? 7'd64 : rcnt_d;
      if (rcnt_d < 7'd16) message_in_d = wbuf_q[rcnt_d[3:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FILL;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      hash_q       <= IV;
      in_ready_q   <= 1'b1;
      control_q    <= 1'b0;
      select_q     <= '0;
      message_in_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      hash_q       <= hash_d;
      in_ready_q   <= in_ready_d;
      control_q    <= control_d;
      select_q     <= select_d;
      message_in_q <= message_in_d;
      out_valid_q  <= out_valid_d;
    end
    wbuf_q <= wbuf_d;
  end

  // The flag alone would read 1 through a multi-cycle reset, so reset masks it.
  assign in_ready   = in_ready_q & ~rst;
  assign control    = control_q;
  assign select     = select_q;
  assign message_in = message_in_q;
  assign out_valid  = out_valid_q;
  assign digest     = hash_q;
  assign {h1, h2, h3, h4, h5, h6, h7, h8} = hash_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Bench for sha256_block_sequencer: a cycle-level SHA-256 round core model drives a..h,
// and digests are checked against a whole-block compression reference and known constants.
module tb_sha256_block_sequencer;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_first = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, control, out_valid;
  logic [6:0]   select;
  logic [31:0]  message_in, h1, h2, h3, h4, h5, h6, h7, h8;
  logic [31:0]  core_a, core_b, core_c, core_d, core_e, core_f, core_g, core_h;
  logic [255:0] digest;

  sha256_block_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .control(control), .select(select), .message_in(message_in),
    .h1(h1), .h2(h2), .h3(h3), .h4(h4), .h5(h5), .h6(h6), .h7(h7), .h8(h8),
    .a(core_a), .b(core_b), .c(core_c), .d(core_d), .e(core_e), .f(core_f), .g(core_g),
    .h(core_h), .out_valid(out_valid), .out_ready(out_ready), .digest(digest)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int last_n = 0;

  always @(posedge clk) if (!rst && in_valid && in_ready) hs_cnt <= hs_cnt + 1;

  logic [31:0] k_tab [64];
  initial k_tab = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] v, input logic [31:0] kw);
    logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, t1, t2;
    {va, vb, vc, vd, ve, vf, vg, vh} = v;
    t1 = vh + (rotr(ve, 6) ^ rotr(ve, 11) ^ rotr(ve, 25)) + ((ve & vf) ^ (~ve & vg)) + kw;
    t2 = (rotr(va, 2) ^ rotr(va, 13) ^ rotr(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
    return {t1 + t2, va, vb, vc, vd + t1, ve, vf, vg};
  endfunction

  // Round core model: loads on control, then performs round t when select presents t.
  logic         core_stub = 1'b0;
  logic [31:0]  stub_val = '0;
  logic [255:0] cv = '0;
  int           ct = 64;
  logic [31:0]  w_core [64];

  always @(posedge clk) begin : core_model
    logic [31:0] wt;
    if (control) begin
      cv <= {h1, h2, h3, h4, h5, h6, h7, h8};
      ct <= 0;
    end else if (ct < 64 && select == 7'(ct)) begin
      if (ct < 16) wt = message_in;
      else wt = w_core[ct-16] + ssig0(w_core[ct-15]) + w_core[ct-7] + ssig1(w_core[ct-2]);
      w_core[ct] = wt;
      cv <= sha_round(cv, k_tab[ct] + wt);
      ct <= ct + 1;
    end
  end

  assign {core_a, core_b, core_c, core_d, core_e, core_f, core_g, core_h} =
    core_stub ? {8{stub_val}} : cv;

  // Reference: whole-block SHA-256 compression of blk onto a chaining value.
  logic [31:0]  blk [16];
  logic [255:0] h_model;

  function automatic logic [255:0] compress(input logic [255:0] hv);
    logic [31:0]  w [64];
    logic [255:0] v, r;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[t];
      else w[t] = w[t-16] + ssig0(w[t-15]) + w[t-7] + ssig1(w[t-2]);
    end
    v = hv;
    for (int t = 0; t < 64; t++) v = sha_round(v, k_tab[t] + w[t]);
    for (int i = 0; i < 8; i++) r[32*i +: 32] = hv[32*i +: 32] + v[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] addw(input logic [255:0] base, input logic [31:0] k);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = base[32*i +: 32] + k;
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " in_ready"}, 256'(in_ready), 256'(0));
    check({tag, " control"}, 256'(control), 256'(0));
    check({tag, " select"}, 256'(select), 256'(0));
    check({tag, " message_in"}, 256'(message_in), 256'(0));
    check({tag, " out_valid"}, 256'(out_valid), 256'(0));
    check({tag, " digest"}, digest, IV);
    check({tag, " h1..h8"}, {h1, h2, h3, h4, h5, h6, h7, h8}, IV);
  endtask

  task automatic load_abc();
    for (int j = 0; j < 16; j++) blk[j] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  // Called at a falling edge; returns at the falling edge after the last accepted word.
  task automatic send_block(input logic first, input bit gaps, input int nwords);
    int   i = 0;
    int   guard = 0;
    logic acc;
    while (i < nwords && guard < 1000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = blk[i];
      in_first = (i == 0) ? first : 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      @(negedge clk);
      guard++;
      if (acc) i++;
    end
    in_valid = 1'b0;
    check("fill words accepted", 256'(i), 256'(nwords));
  endtask

  logic        ctl_log [$];
  logic [6:0]  sel_log [$];
  logic [31:0] msg_log [$];

  // Logs core-facing outputs from the LOAD cycle until out_valid rises.
  task automatic wait_out();
    int n = 0;
    ctl_log.delete();
    sel_log.delete();
    msg_log.delete();
    while (n < 300) begin
      ctl_log.push_back(control);
      sel_log.push_back(select);
      msg_log.push_back(message_in);
      if (out_valid) break;
      @(negedge clk);
      n++;
    end
    last_n = n;
    check("out_valid rises", 256'(out_valid), 256'(1));
    // The period after the accepting edge N is cycle N+1.
    check("latency", 256'(n + 1), 256'(69));
  endtask

  task automatic check_seq();
    int es;
    if (ctl_log.size() >= 69) begin
      for (int k = 0; k < 69; k++) begin
        es = (k >= 1 && k <= 66) ? k - 1 : 0;
        if (es > 64) es = 64;
        check($sformatf("control[%0d]", k), 256'(ctl_log[k]), 256'(k == 0));
        check($sformatf("select[%0d]", k), 256'(sel_log[k]), 256'(es));
        if (k >= 1 && k <= 66)
          check($sformatf("message_in[%0d]", k), 256'(msg_log[k]),
                256'((k - 1 < 16) ? blk[k-1] : 32'h0));
      end
    end
  endtask

  typedef struct {
    logic [31:0]  stub;
    logic         first;
    logic [31:0]  exp_h0;
    logic [255:0] exp;
  } vec_t;

  vec_t        tbl [5];
  logic [31:0] rblk [4][16];
  logic        rfirst [4];
  logic [255:0] d0;
  int          hs0, hs1, stall;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h00000001, 1'b1, 32'h6a09e668, addw(IV, 32'h00000001)};
    tbl[1] = '{32'h00000001, 1'b0, 32'h6a09e669, addw(IV, 32'h00000002)};
    tbl[2] = '{32'hffffffff, 1'b1, 32'h6a09e666, addw(IV, 32'hffffffff)};
    tbl[3] = '{32'hffffffff, 1'b0, 32'h6a09e665, addw(IV, 32'hfffffffe)};
    tbl[4] = '{32'h00000000, 1'b0, 32'h6a09e665, addw(IV, 32'hfffffffe)};

    // Reset
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    #1;
    check("in_ready after reset", 256'(in_ready), 256'(1));
    @(negedge clk);

    // "abc" through the round core model
    out_ready = 1'b1;
    load_abc();
    send_block(1'b1, 1'b0, 16);
    wait_out();
    check("abc digest", digest, ABC_DIGEST);
    check_seq();
    @(negedge clk);
    check("fill after out in_ready", 256'(in_ready), 256'(1));
    check("fill after out out_valid", 256'(out_valid), 256'(0));

    // Stub core: IV plus constants, chaining and mod 2^32 wrap
    core_stub = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stub_val = tbl[i].stub;
      for (int j = 0; j < 16; j++) blk[j] = $urandom;
      send_block(tbl[i].first, 1'b0, 16);
      wait_out();
      check($sformatf("stub[%0d] H0", i), 256'(digest[255:224]), 256'(tbl[i].exp_h0));
      check($sformatf("stub[%0d] digest", i), digest, tbl[i].exp);
      check_seq();
      @(negedge clk);
    end

    // Random blocks with gappy input, next word held during ROUND/OUT, output stalls
    core_stub = 1'b0;
    out_ready = 1'b0;
    h_model = IV;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 16; j++) rblk[b][j] = $urandom;
      rfirst[b] = (b == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 16; j++) blk[j] = rblk[b][j];
      if (rfirst[b]) h_model = IV;
      h_model = compress(h_model);
      hs0 = hs_cnt;
      send_block(rfirst[b], 1'b1, 16);
      check($sformatf("rand[%0d] words", b), 256'(hs_cnt - hs0), 256'(16));
      hs1 = hs_cnt;
      if (b < 3) begin
        in_valid = 1'b1;
        in_data  = rblk[b+1][0];
        in_first = rfirst[b+1];
      end
      wait_out();
      check_seq();
      d0 = digest;
      stall = (b == 1) ? 20 : $urandom_range(0, 4);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall out_valid", 256'(out_valid), 256'(1));
        check("stall digest", digest, d0);
        check("stall in_ready", 256'(in_ready), 256'(0));
      end
      check($sformatf("rand[%0d] digest", b), digest, h_model);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out handshake out_valid", 256'(out_valid), 256'(0));
      check("out handshake in_ready", 256'(in_ready), 256'(1));
      check("no words outside fill", 256'(hs_cnt), 256'(hs1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Reset in the middle of FILL, then "abc" chaining from the restored IV
    for (int j = 0; j < 16; j++) blk[j] = $urandom;
    send_block(1'b0, 1'b1, 5);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("fill reset");
    rst = 1'b0;
    #1;
    check("fill reset in_ready", 256'(in_ready), 256'(1));
    load_abc();
    send_block(1'b0, 1'b0, 16);
    wait_out();
    check("abc after fill reset", digest, ABC_DIGEST);
    @(negedge clk);

    // Reset at rcnt=30, then "abc" again with in_first=0
    for (int j = 0; j < 16; j++) blk[j] = $urandom;
    send_block(1'b0, 1'b0, 16);
    repeat (31) @(negedge clk);
    check("select at rcnt 30", 256'(select), 256'(30));
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("round reset");
    rst = 1'b0;
    #1;
    check("round reset in_ready", 256'(in_ready), 256'(1));
    load_abc();
    send_block(1'b0, 1'b0, 16);
    wait_out();
    check("abc after round reset", digest, ABC_DIGEST);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
